// File: rtl/max_share_sched.sv
// -----------------------------------------------------------------------------
// max_share_sched
//
// Time-shares one external approximate-max datapath among NREQ requesters.
// A round-robin arbiter picks one valid requester whenever the one-entry
// response buffer is free. The arbiter drives that requester's operands onto
// the shared datapath and captures the datapath result in the buffer. Each
// result is compared against an exact max computed locally. A saturating
// counter tracks how many accepted requests disagreed with the exact max.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept, one-hot or zero
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing
//   dp_a       operand A driven to the shared datapath
//   dp_b       operand B driven to the shared datapath
//   dp_y       datapath result, combinational from dp_a/dp_b
//   cfg_exact  1 = return the exact max instead of dp_y
//   stat_clr   synchronous clear of err_cnt (wins over an increment)
//   rsp_valid  response buffer holds a result
//   rsp_ready  consumer accepts the response
//   rsp_id     index of the requester that produced the result
//   rsp_y      result
//   rsp_err    datapath result differed from the exact max
//   err_cnt    saturating count of mismatching accepted requests
// -----------------------------------------------------------------------------
module max_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int CNTW  = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      dp_a,
  output logic [WIDTH-1:0]      dp_b,
  input  logic [WIDTH-1:0]      dp_y,
  input  logic                  cfg_exact,
  input  logic                  stat_clr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_err,
  output logic [CNTW-1:0]       err_cnt
);

  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Unsigned exact max, the reference the datapath result is judged against.
  function automatic logic [WIDTH-1:0] max_u(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // State
  logic [IDW-1:0]   ptr_r;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [WIDTH-1:0] rsp_y_r;
  logic             rsp_err_r;
  logic [CNTW-1:0]  err_cnt_r;

  // Combinational
  logic             buf_free_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             grant_vld_s;
  logic [IDW-1:0]   sel_s;
  logic [WIDTH-1:0] exact_s;
  logic             mismatch_s;

  // Buffer can take a new result when empty or being drained this cycle.
  assign buf_free_s = ~rsp_valid_r | rsp_ready;

  // Round-robin search starting at ptr_r. The loop walks offsets from the
  // farthest to the nearest, so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx_s = ptr_r;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx         = (int'(ptr_r) + k) % NREQ;
      grant_idx_s = req_valid[idx] ? IDW'(idx) : grant_idx_s;
    end
    grant_vld_s = ~rst & buf_free_s & (|req_valid);
  end

  // One-hot ready for the granted requester only.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (grant_vld_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Without a grant, the datapath sees requester ptr_r so its inputs are never X.
  assign sel_s      = grant_vld_s ? grant_idx_s : ptr_r;
  assign dp_a       = req_a[int'(sel_s) * WIDTH +: WIDTH];
  assign dp_b       = req_b[int'(sel_s) * WIDTH +: WIDTH];
  assign exact_s    = max_u(dp_a, dp_b);
  assign mismatch_s = (dp_y != exact_s);

  // Response buffer and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= {IDW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {IDW{1'b0}};
      rsp_y_r     <= {WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (grant_vld_s) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= grant_idx_s;
      rsp_y_r     <= cfg_exact ? exact_s : dp_y;
      rsp_err_r   <= mismatch_s;
      ptr_r       <= (grant_idx_s == LAST_ID) ? {IDW{1'b0}} : grant_idx_s + IDW'(1);
    end else if (rsp_ready) begin
      // Drain with no new accept: the data fields keep their last value.
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  // Saturating mismatch counter; a clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= {CNTW{1'b0}};
    end else if (stat_clr) begin
      err_cnt_r <= {CNTW{1'b0}};
    end else if (grant_vld_s && mismatch_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNTW'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_y     = rsp_y_r;
  assign rsp_err   = rsp_err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_max_share_sched.sv
// -----------------------------------------------------------------------------
// tb_max_share_sched
//
// Directed bench for max_share_sched with NREQ=4, WIDTH=4, CNTW=4.
// The external datapath is modelled as an exact max of dp_a/dp_b. This model
// can be overridden with a forced value to create mismatches.
// -----------------------------------------------------------------------------
module tb_max_share_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int CNTW  = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      dp_a;
  logic [WIDTH-1:0]      dp_b;
  logic [WIDTH-1:0]      dp_y;
  logic                  cfg_exact;
  logic                  stat_clr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_y;
  logic                  rsp_err;
  logic [CNTW-1:0]       err_cnt;

  logic                  force_en;
  logic [WIDTH-1:0]      force_val;

  int checks_r;
  int errors_r;

  max_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_y      (dp_y),
    .cfg_exact (cfg_exact),
    .stat_clr  (stat_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt)
  );

  // External approximate datapath: exact unless forced.
  assign dp_y = force_en ? force_val : ((dp_a > dp_b) ? dp_a : dp_b);

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    logic [3:0] exp_y [4];
    checks_r  = 0;
    errors_r  = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    cfg_exact = 1'b0;
    stat_clr  = 1'b0;
    rsp_ready = 1'b1;
    force_en  = 1'b0;
    force_val = 4'd0;

    // 1. Reset, then a single request from requester 0.
    set_ops(0, 4'd9, 4'd5);
    req_valid = 4'b0001;
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_y", 32'(rsp_y), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    #2;
    check("t1_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_y", 32'(rsp_y), 32'd9);
    check("t1_err", 32'(rsp_err), 32'd0);
    check("t1_cnt", 32'(err_cnt), 32'd0);

    // 2. Round-robin from ptr=0 with every requester valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_ops(0, 4'd1, 4'd10);
    set_ops(1, 4'd2, 4'd9);
    set_ops(2, 4'd3, 4'd8);
    set_ops(3, 4'd4, 4'd7);
    exp_y[0] = 4'd10;
    exp_y[1] = 4'd9;
    exp_y[2] = 4'd8;
    exp_y[3] = 4'd7;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #2;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_y", 32'(rsp_y), 32'(exp_y[k % 4]));
    end
    req_valid = 4'b0000;

    // 3. Backpressure: buffer holds grant-0 result (10); ptr is 1.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #2;
    check("bp_ready0", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_y", 32'(rsp_y), 32'd10);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    #2;
    check("bp_pass_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    check("bp_id1", 32'(rsp_id), 32'd1);
    check("bp_y1", 32'(rsp_y), 32'd9);

    // 4. Mismatch and exact bypass (ptr is 2).
    set_ops(2, 4'd12, 4'd3);
    force_en  = 1'b1;
    force_val = 4'd8;
    cfg_exact = 1'b0;
    req_valid = 4'b0100;
    step();
    check("mm_y", 32'(rsp_y), 32'd8);
    check("mm_err", 32'(rsp_err), 32'd1);
    check("mm_cnt", 32'(err_cnt), 32'd1);
    cfg_exact = 1'b1;
    step();
    check("ex_id", 32'(rsp_id), 32'd2);
    check("ex_y", 32'(rsp_y), 32'd12);
    check("ex_err", 32'(rsp_err), 32'd1);
    check("ex_cnt", 32'(err_cnt), 32'd2);
    // Changing cfg_exact must not alter a held result.
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    cfg_exact = 1'b0;
    step();
    check("cfg_hold_y", 32'(rsp_y), 32'd12);
    // Drain with no accept: valid drops and the data holds.
    rsp_ready = 1'b1;
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_y", 32'(rsp_y), 32'd12);

    // 5. Counter saturation at 15, then clear beats an increment.
    req_valid = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step();
      check("sat_cnt", 32'(err_cnt), 32'(((3 + k) > 15) ? 15 : (3 + k)));
    end
    stat_clr = 1'b1;
    step();
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_err", 32'(rsp_err), 32'd1);
    stat_clr = 1'b0;
    step();
    check("post_clr_cnt", 32'(err_cnt), 32'd1);
    force_en  = 1'b0;

    // 6. Move ptr to 2 (grant 1 from ptr 3), then reset mid-operation.
    req_valid = 4'b0010;
    step();
    check("pre_rst_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    rst       = 1'b1;
    #2;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cnt", 32'(err_cnt), 32'd0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #2;
    check("post_rst_ready", 32'(req_ready), 32'b0010);
    step();
    check("post_rst_id", 32'(rsp_id), 32'd1);
    check("post_rst_y", 32'(rsp_y), 32'd9);
    req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
